// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_BLANK : active-low code with every segment off
//   state_t   : scan FSM state (BLANK gap / DRIVE one digit)
//   SEG_ROM   : active-low {a,b,c,d,e,f,g} codes for nibbles 0..15;
//               non-BCD nibbles 10..15 decode to all-off
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_ROM [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        SEG_BLANK,   // 10
        SEG_BLANK,   // 11
        SEG_BLANK,   // 12
        SEG_BLANK,   // 13
        SEG_BLANK,   // 14
        SEG_BLANK    // 15
    };

endpackage

// File: rtl/sevenseg_digit_rom.sv
// Combinational nibble-to-segment decoder.
//   nibble : 4-bit digit value
//   code   : active-low {a,b,c,d,e,f,g}, a = bit 6
module sevenseg_digit_rom
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    assign code = SEG_ROM[nibble];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit gets a BLANK gap (all digits off) followed by a DRIVE dwell.
// New values arrive through a valid/ready handshake into a shadow register
// and are copied to the display registers only at a frame boundary.
//   clk, rst     : clock, asynchronous active-high reset
//   load_valid   : new value offered
//   load_ready   : shadow register free (no value pending)
//   load_bcd     : BCD nibbles, nibble 0 = least-significant digit
//   load_dp      : decimal point per digit, 1 = lit
//   lz_blank_en  : leading-zero blanking enable
//   seg, dp, an  : active-low segment bus, decimal point, digit enables
//   frame_done   : one-cycle pulse at each frame boundary
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 12000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_bcd,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    input  logic                      lz_blank_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // With no gap configured, BLANK is only ever the one-cycle reset state.
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] shd_bcd_q, shd_bcd_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic                    pending_q, pending_d;

    logic                    boundary;
    logic                    lz_zero;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              nibble_sel;
    logic [6:0]              rom_code;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    // Single decoder on the digit about to be shown, so outputs can be
    // registered on the same edge the FSM moves.
    sevenseg_digit_rom u_rom (
        .nibble (nibble_sel),
        .code   (rom_code)
    );

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + 1'b1;
        boundary   = 1'b0;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        shd_bcd_d  = shd_bcd_q;
        shd_dp_d   = shd_dp_q;
        pending_d  = pending_q;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = BLANK;
        endcase

        // Copy and capture are mutually exclusive: ready is low while pending.
        if (boundary && pending_q) begin
            disp_bcd_d = shd_bcd_q;
            disp_dp_d  = shd_dp_q;
            pending_d  = 1'b0;
        end
        if (load_valid && load_ready) begin
            shd_bcd_d = load_bcd;
            shd_dp_d  = load_dp;
            pending_d = 1'b1;
        end

        // A digit is a leading zero if it and every more-significant digit
        // are zero; digit 0 is always shown.
        lz_zero = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_zero    = lz_zero & (disp_bcd_d[i*4 +: 4] == 4'd0);
            lz_mask[i] = lz_zero;
        end

        nibble_sel = disp_bcd_d[int'(idx_d)*4 +: 4];

        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = (lz_blank_en && lz_mask[idx_d]) ? SEG_BLANK : rom_code;
            dp_d        = ~disp_dp_d[idx_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    // NOTE: display and shadow registers are reset so the first frame after
    // reset shows a defined value and any pending load is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            cnt_q      <= '0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            shd_bcd_q  <= '0;
            shd_dp_q   <= '0;
            pending_q  <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            shd_bcd_q  <= shd_bcd_d;
            shd_dp_q   <= shd_dp_d;
            pending_q  <= pending_d;
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_done <= boundary;
            load_ready <= ~pending_d;
        end
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode seven-segment display on the Vaman FPGA board. Drives one shared active-low segment bus plus per-digit active-low enables. It holds a displayed BCD value, accepts new values through a valid/ready handshake, and applies them only at frame boundaries so no frame shows mixed data. A blanking gap between digits prevents ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DWELL_CYCLES, 12000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 200, clk cycles all digits are off before each digit is driven (>=0; 0 removes the BLANK state)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
load_valid  input  1  new display value offered
load_ready  output  1  controller can accept a value
load_bcd  input  4*NUM_DIGITS  BCD nibbles; nibble 0 [3:0] = least-significant digit
load_dp  input  NUM_DIGITS  decimal point per digit, 1 = lit
lz_blank_en  input  1  leading-zero blanking enable, sampled every cycle
seg  output  7  {a,b,c,d,e,f,g}, a = bit 6, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit enables, active-low
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release): state BLANK, digit index 0, counter 0, seg=7'b1111111, dp=1, an=all ones, frame_done=0, display regs = 0, pending=0, load_ready=0 while rst is high, then 1.
- All outputs are registered and change on the clk edge where the state or digit changes.
- FSM:
  - BLANK: an all ones, seg/dp all ones, for BLANK_CYCLES, then DRIVE.
  - DRIVE: an[idx]=0, others 1, seg=decode(display nibble idx), dp=~display_dp[idx], for DWELL_CYCLES.
  - Leaving DRIVE: if idx<NUM_DIGITS-1, idx+1 and go to BLANK. Otherwise this is the frame boundary: idx=0, go to BLANK.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Segment decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 = 1111111
- Handshake:
  - load_ready = !pending (and 0 during reset).
  - Transfer when load_valid & load_ready at a clk edge: load_bcd and load_dp are captured into the shadow regs, and pending becomes 1.
  - Data must be held stable only during the transfer cycle.
- Frame boundary edge:
  - frame_done=1 for that one cycle.
  - If pending, shadow copies to the display regs and pending clears, so load_ready rises on the next cycle.
  - No load can collide with the copy, because ready=0 while pending.
- Leading-zero blanking, when lz_blank_en=1:
  - A digit is blanked (seg=1111111) if its nibble is 0 and every more-significant nibble is 0.
  - Digit 0 is never blanked.
  - dp is still driven from display_dp.
- Reset asserted mid-operation forces all reset values immediately. Any pending shadow value is discarded.
- Counters are $clog2-sized and wrap only through explicit FSM reload. They never free-run past their terminal count.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_BLANK = 7'b1111111
  - a typedef for the FSM state enum {BLANK, DRIVE}
  - the 16-entry segment code constants
- One combinational sub-module, sevenseg_digit_rom: 4-bit nibble in, 7-bit active-low code out. It is instanced once on the muxed nibble.
- The FSM, counters, handshake and LZB logic live in the top block.

Test Plan:
- Reset: after rst pulse mid-DRIVE, check seg=1111111, an=1111, dp=1, frame_done=0 immediately; check load_ready=1 one cycle after release.
- Scan order (DWELL=4, BLANK=2), load 0x1234:
  - After the first frame boundary, each 6-cycle slot shows 2 cycles all-off, then 4 cycles of each digit in turn:
    - an=1110 with seg=1001100 ("4")
    - an=1101 with 0000110 ("3")
    - an=1011 with 0010010 ("2")
    - an=0111 with 1001111 ("1")
  - frame_done pulses every 24 cycles.
- Deferred update: load 0x5678 mid-frame; check load_ready=0 until the boundary and the old digits held for the rest of the frame; the new value appears from digit 0 of the next frame.
- Leading-zero blanking: load 0x0007, lz_blank_en=1 → digits 3..1 show 1111111 and digit 0 shows 0001111. Load 0x0000 → only digit 0 lit, as 0000001.
- Invalid code and dp: load 0x00A9 with load_dp=0001 and lz_blank_en=0:
  - digit 0 shows 0000100 with dp=0
  - digit 1 shows 1111111
  - digits 2 and 3 show 0000001
- BLANK_CYCLES=0: check no all-off gap and a frame length of NUM_DIGITS*DWELL.
